// File: rtl/hart_imem_arbiter_pkg.sv
// Shared types and helpers for the hart instruction-memory arbiter.
package arvi_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  // Index width that never collapses to zero bits for a single hart.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hart_imem_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping.
module rr_picker
  import arvi_arb_pkg::*;
#(
  parameter int NUM_HARTS = 2,
  localparam int IDX_W = clog2_min1(NUM_HARTS)
) (
  input  logic [NUM_HARTS-1:0] req_i,
  input  logic [IDX_W-1:0]     ptr_i,
  output logic                 valid_o,
  output logic [IDX_W-1:0]     idx_o
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = NUM_HARTS - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(ptr_i) + k) % NUM_HARTS);
      if (req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/hart_imem_arbiter.sv
// Round-robin arbiter sharing one instruction-memory port among NUM_HARTS fetch ports.
module hart_imem_arbiter
  import arvi_arb_pkg::*;
#(
  parameter int NUM_HARTS = 2,
  parameter int XLEN      = 32,
  localparam int IDX_W    = clog2_min1(NUM_HARTS)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_HARTS-1:0]      i_IC_DataReq,
  input  logic [NUM_HARTS*XLEN-1:0] i_IM_Addr,
  output logic [NUM_HARTS-1:0]      o_IC_MemReady,
  output logic [NUM_HARTS*XLEN-1:0] o_IM_Instr,
  output logic                      o_IC_DataReq,
  output logic [XLEN-1:0]           o_IM_Addr,
  input  logic                      i_IC_MemReady,
  input  logic [XLEN-1:0]           i_IM_Instr,
  output logic [IDX_W-1:0]          o_grant,
  output logic                      o_busy
);

  arb_state_t                state_q, state_d;
  logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]          grant_q, grant_d;
  logic [XLEN-1:0]           addr_q, addr_d;
  logic [NUM_HARTS*XLEN-1:0] instr_q, instr_d;
  logic                      pick_vld;
  logic [IDX_W-1:0]          pick_idx;

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] g);
    return IDX_W'((int'(g) + 1) % NUM_HARTS);
  endfunction

  rr_picker #(
    .NUM_HARTS(NUM_HARTS)
  ) u_picker (
    .req_i   (i_IC_DataReq),
    .ptr_i   (rr_ptr_q),
    .valid_o (pick_vld),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    instr_d  = instr_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          addr_d  = i_IM_Addr[int'(pick_idx)*XLEN +: XLEN];
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (i_IC_MemReady) begin
          instr_d[int'(grant_q)*XLEN +: XLEN] = i_IM_Instr;
          state_d = ARB_RESP;
        end
      end
      ARB_RESP: begin
        rr_ptr_d = next_ptr(grant_q);
        state_d  = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      addr_q   <= '0;
      instr_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      instr_q  <= instr_d;
    end
  end

  // Strobe is masked by reset so a response abandoned mid-flight never reaches a hart.
  always_comb begin
    o_IC_MemReady = '0;
    if (state_q == ARB_RESP && !i_rst) o_IC_MemReady[grant_q] = 1'b1;
  end

  assign o_IC_DataReq = (state_q == ARB_BUSY);
  assign o_IM_Addr    = addr_q;
  assign o_IM_Instr   = instr_q;
  assign o_grant      = grant_q;
  assign o_busy       = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_hart_imem_arbiter.sv
// Scoreboard bench for hart_imem_arbiter with four harts and a random memory model.
module tb_hart_imem_arbiter;

  localparam int N = 4;
  localparam int XL = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic [XL-1:0] haddr [N];
  logic [N*XL-1:0] addr_bus;
  logic [N-1:0]  strb;
  logic [N*XL-1:0] instr;
  logic          dreq;
  logic [XL-1:0] maddr;
  logic          mem_rdy = 1'b0;
  logic [XL-1:0] mem_data = '0;
  logic [1:0]    grant;
  logic          busy;

  typedef struct {
    int          h;
    logic [31:0] d;
  } exp_t;

  exp_t        sbq [$];
  exp_t        mon_e;
  logic [31:0] lane_m [N];
  logic [N-1:0] prev_strb = '0;
  logic [N*XL-1:0] lane_vec;

  int checks = 0;
  int failures = 0;
  int lat;
  int ref_ptr, cur_h, wcnt, found;
  int waitc [N];
  logic [N-1:0] req_app;
  logic prev_dreq;

  always #5 clk = ~clk;

  always_comb
    for (int h = 0; h < N; h++) addr_bus[h*XL +: XL] = haddr[h];

  hart_imem_arbiter #(.NUM_HARTS(N), .XLEN(XL)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_IC_DataReq  (req),
    .i_IM_Addr     (addr_bus),
    .o_IC_MemReady (strb),
    .o_IM_Instr    (instr),
    .o_IC_DataReq  (dreq),
    .o_IM_Addr     (maddr),
    .i_IC_MemReady (mem_rdy),
    .i_IM_Instr    (mem_data),
    .o_grant       (grant),
    .o_busy        (busy)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model;
    sbq.delete();
    for (int h = 0; h < N; h++) lane_m[h] = '0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    req = '0;
    mem_rdy = 1'b0;
    clear_model();
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic push_exp(input int h, input logic [31:0] d);
    exp_t t;
    t.h = h;
    t.d = d;
    sbq.push_back(t);
  endtask

  // Wait (bounded) for a grant, check it, hold for `waits` cycles, then return data.
  task automatic serve(input int exp_h, input int waits, input logic [31:0] data);
    int cnt;
    tick();
    cnt = 1;
    while (dreq !== 1'b1 && cnt < 12) begin
      tick();
      cnt++;
    end
    lat = cnt;
    chk("grant_dreq", dreq, 1);
    chk("grant_idx", grant, exp_h);
    chk("grant_addr", maddr, haddr[exp_h]);
    chk("grant_busy", busy, 1);
    repeat (waits) begin
      tick();
      chk("hold_dreq", dreq, 1);
      chk("hold_addr", maddr, haddr[exp_h]);
    end
    mem_data = data;
    mem_rdy  = 1'b1;
    push_exp(exp_h, data);
    tick();
    mem_rdy  = 1'b0;
    mem_data = $urandom;
    chk("resp_dreq", dreq, 0);
    chk("resp_busy", busy, 1);
  endtask

  // Monitor: every presented strobe pops one expectation; lanes must match the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (strb !== '0) begin
          chk("strobe_onehot", $onehot(strb), 1);
          chk("strobe_width", prev_strb, 0);
          if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_strobe actual=%b required=none", strb);
          end else begin
            mon_e = sbq.pop_front();
            chk("strobe_lane", strb, 4'b0001 << mon_e.h);
            lane_m[mon_e.h] = mon_e.d;
          end
        end
        for (int h = 0; h < N; h++) lane_vec[h*XL +: XL] = lane_m[h];
        chk("lanes", instr, lane_vec);
      end
      prev_strb = strb;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int h = 0; h < N; h++) haddr[h] = '0;

    // Reset then idle
    do_reset(2);
    chk("rst_dreq", dreq, 0);
    chk("rst_addr", maddr, 0);
    chk("rst_strb", strb, 0);
    chk("rst_instr", instr, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    repeat (20) begin
      tick();
      chk("idle_dreq", dreq, 0);
    end

    // Single hart, zero-wait memory
    haddr[1] = 32'h0000_0100;
    req = 4'b0010;
    serve(1, 0, 32'h0000_0013);
    chk("single_latency", lat, 1);
    chk("single_strb", strb, 4'b0010);
    chk("single_lane1", instr[63:32], 32'h13);
    chk("single_lane0", instr[31:0], 0);
    req = '0;
    tick();
    chk("single_post_strb", strb, 0);
    chk("single_post_busy", busy, 0);

    // Late arrival: hart0 busy, hart2 then hart1 request; rr_ptr=1 picks hart1 first
    haddr[0] = 32'h0000_0200;
    req = 4'b0001;
    tick();
    chk("late_dreq", dreq, 1);
    chk("late_grant0", grant, 0);
    haddr[2] = 32'h0000_0280;
    req[2] = 1'b1;
    tick();
    haddr[1] = 32'h0000_0240;
    req[1] = 1'b1;
    tick();
    mem_data = 32'h1111_0000;
    mem_rdy = 1'b1;
    push_exp(0, mem_data);
    tick();
    mem_rdy = 1'b0;
    req[0] = 1'b0;
    serve(1, 1, $urandom);
    req[1] = 1'b0;
    serve(2, 0, $urandom);
    req[2] = 1'b0;
    tick();

    // Round robin, all four requesting, 2 wait-states
    do_reset(2);
    for (int h = 0; h < N; h++) haddr[h] = 32'h1000 + 32'(h * 16);
    req = 4'b1111;
    for (int i = 0; i < 6; i++) serve(i % N, 2, $urandom);
    req = '0;
    repeat (2) tick();

    // Dropped request: hart3 lets go during BUSY, strobe still issued
    do_reset(2);
    haddr[3] = 32'h0000_0300;
    req = 4'b1000;
    tick();
    chk("drop_dreq", dreq, 1);
    chk("drop_grant", grant, 3);
    req = '0;
    tick();
    chk("drop_hold", dreq, 1);
    mem_data = 32'hDEAD_BEEF;
    mem_rdy = 1'b1;
    push_exp(3, mem_data);
    tick();
    mem_rdy = 1'b0;
    chk("drop_strb", strb, 4'b1000);
    chk("drop_lane3", instr[127:96], 32'hDEAD_BEEF);
    tick();
    req = 4'b1001;
    serve(0, 0, $urandom);
    req[0] = 1'b0;
    serve(3, 0, $urandom);
    req = '0;
    repeat (2) tick();

    // Reset in the BUSY cycle; a late memory ready must not produce a strobe
    haddr[2] = 32'h0000_0400;
    req = 4'b0100;
    tick();
    chk("mrst_busy_dreq", dreq, 1);
    chk("mrst_grant", grant, 2);
    rst = 1'b1;
    clear_model();
    tick();
    chk("mrst_dreq", dreq, 0);
    rst = 1'b0;
    req = '0;
    mem_rdy = 1'b1;
    mem_data = 32'h0000_0BAD;
    tick();
    mem_rdy = 1'b0;
    chk("mrst_strb", strb, 0);
    chk("mrst_dreq2", dreq, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_grant0", grant, 0);
    repeat (5) begin
      tick();
      chk("mrst_idle_dreq", dreq, 0);
      chk("mrst_idle_strb", strb, 0);
    end

    // Randomized traffic against a round-robin reference
    do_reset(2);
    ref_ptr = 0;
    cur_h = 0;
    wcnt = 0;
    prev_dreq = 1'b0;
    for (int h = 0; h < N; h++) waitc[h] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      req_app = req;
      tick();
      if (dreq && !prev_dreq) begin
        found = -1;
        for (int k = N - 1; k >= 0; k--)
          if (req_app[(ref_ptr + k) % N]) found = (ref_ptr + k) % N;
        if (found < 0) begin
          checks++;
          failures++;
          $display("FAIL rnd_spurious_grant actual=%0d required=no_request", grant);
        end else begin
          chk("rnd_grant", grant, found);
          chk("rnd_addr", maddr, haddr[found]);
          cur_h = found;
        end
        wcnt = $urandom_range(0, 3);
      end
      mem_data = $urandom;
      if (dreq) begin
        mem_rdy = 1'b0;
        if (wcnt == 0) begin
          mem_rdy = 1'b1;
          push_exp(cur_h, mem_data);
          ref_ptr = (cur_h + 1) % N;
        end else begin
          wcnt--;
        end
      end else begin
        mem_rdy = ($urandom_range(0, 7) == 0);
      end
      for (int h = 0; h < N; h++) begin
        if (req[h]) waitc[h]++;
        if (req[h] && strb[h]) begin
          chk("rnd_wait_bound", waitc[h] <= 40, 1);
          waitc[h] = 0;
          req[h] = 1'b0;
        end else if (!req[h] && cyc < 2950 && $urandom_range(0, 3) == 0) begin
          haddr[h] = $urandom;
          req[h] = 1'b1;
        end
      end
      prev_dreq = dreq;
    end
    mem_rdy = 1'b0;
    repeat (3) tick();
    chk("rnd_drained", sbq.size(), 0);
    chk("rnd_final_dreq", dreq, 0);
    chk("rnd_final_req", req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hart_imem_arbiter.md
Name: hart_imem_arbiter

Overview:
Round-robin arbiter that lets NUM_HARTS harts share one instruction-memory (I-cache refill) port in a multi-hart build. It sits between the per-hart fetch ports and the single memory-side port, and uses the same req/ready handshake on both sides. Exactly one transaction is outstanding at a time. Responses are registered and routed only to the granted hart.

Parameters:
NUM_HARTS, 2, number of hart fetch ports (1..16)
XLEN, 32, address and instruction width
IDX_W, (NUM_HARTS>1 ? $clog2(NUM_HARTS) : 1), grant index width (derived, localparam)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_IC_DataReq  in  NUM_HARTS  per-hart fetch request, level
i_IM_Addr  in  NUM_HARTS*XLEN  per-hart fetch address; hart h uses bits [h*XLEN +: XLEN]
o_IC_MemReady  out  NUM_HARTS  per-hart 1-cycle response strobe
o_IM_Instr  out  NUM_HARTS*XLEN  per-hart returned instruction, packed like i_IM_Addr
o_IC_DataReq  out  1  memory-side request
o_IM_Addr  out  XLEN  memory-side address
i_IC_MemReady  in  1  memory-side ready strobe
i_IM_Instr  in  XLEN  memory-side instruction data
o_grant  out  IDX_W  index of the hart currently or last served (debug/perf)
o_busy  out  1  high while in BUSY or RESP

Behaviour:
- One clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset values:
  - state=IDLE, rr_ptr=0, o_grant=0.
  - o_IC_DataReq=0, o_IM_Addr=0, o_IC_MemReady=0.
  - All o_IM_Instr lanes=0, o_busy=0.
- Hart contract: hold req and address stable until its o_IC_MemReady strobe.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If any req is set, select the first requesting index at or after rr_ptr, wrapping modulo NUM_HARTS.
  - Register the grant index into o_grant and register the selected address into o_IM_Addr.
  - Go to BUSY.
  - If no req is set, stay in IDLE.
- BUSY:
  - o_IC_DataReq=1 and o_IM_Addr is held.
  - Wait for i_IC_MemReady. On that cycle, capture i_IM_Instr into lane o_grant and go to RESP.
  - i_IC_MemReady seen outside BUSY is ignored.
- RESP:
  - o_IC_MemReady[o_grant]=1 for exactly this cycle; all other lanes are 0. o_IC_DataReq=0.
  - rr_ptr <= (o_grant+1) mod NUM_HARTS. Go to IDLE.
- Latency: request visible in IDLE → o_IC_DataReq high at +1 cycle. Memory ready → hart strobe at +1 cycle. Minimum period per fetch: 3 cycles with a zero-wait memory.
- o_IM_Instr lanes hold their last value until that hart's next response.
- Fairness:
  - The hart just served has lowest priority at the next arbitration.
  - With all harts requesting continuously, grants are issued 0,1,..,N-1,0,...
  - No hart waits more than N-1 other transactions.
- Hart drops req while BUSY: the transaction still completes and the strobe is still issued. No abort.
- Request arriving during BUSY/RESP: it is held pending and becomes eligible at the next IDLE.
- i_rst during BUSY or RESP: state=IDLE at the next edge and o_IC_DataReq=0; any pending strobe is suppressed. Memory must tolerate the abandoned request.
- NUM_HARTS=1: rr_ptr is constant 0; behaviour is identical otherwise.

Decomposition:
- Package arvi_arb_pkg holds:
  - typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RESP} arb_state_t
  - function clog2_min1 for IDX_W
- One sub-module, rr_picker: combinational. Inputs are a req vector and rr_ptr; outputs are a valid bit and the chosen index. It is parametrised by NUM_HARTS.
- The FSM, address/data registers and lane demux stay in hart_imem_arbiter.

Test Plan:
- Reset then idle: hold i_rst 2 cycles → all outputs 0; with no req, o_IC_DataReq stays 0 for 20 cycles.
- Single hart, zero-wait memory: hart1 requests addr 0x0000_0100. Then:
  - o_IC_DataReq=1 and o_IM_Addr=0x100 one cycle later.
  - Memory returns 0x0000_0013 with ready in that cycle.
  - Next cycle o_IC_MemReady=2'b10 and lane1=0x13; lane0 is unchanged at 0.
- Round-robin, NUM_HARTS=4: all four request continuously, memory with 2 wait-states → grant order 0,1,2,3,0,1. Each o_IC_MemReady strobe is 1 cycle wide and 1-hot.
- Simultaneous late arrival: hart0 granted (BUSY); hart2 then hart1 raise req → after hart0 completes, hart1 is granted before hart2 (rr_ptr=1).
- Reset mid-transaction: assert i_rst in the BUSY cycle, then return i_IC_MemReady=1 on the next cycle → no o_IC_MemReady strobe; state returns to IDLE; o_IC_DataReq=0.
- Dropped request: hart3 deasserts req during BUSY; memory replies 0xDEAD_BEEF → o_IC_MemReady[3] still pulses and lane3=0xDEADBEEF; next grant follows rr_ptr=0.
